// File: rtl/nn_fixed_pkg.sv
// Shared Q5.12 fixed-point constants and the MAC controller state encoding.
package nn_fixed_pkg;
  localparam int Q_W         = 18;
  localparam int Q_FRAC_BITS = 12;

  localparam logic [Q_W-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [Q_W-1:0] SAT_MIN = 18'h20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    SCALE = 2'd3
  } mac_state_e;
endpackage

// File: rtl/fixed_sat_round.sv
// Combinational wide-accumulator to Q5.12 conversion: arithmetic shift
// (floor) followed by signed saturation to 18 bits.
module fixed_sat_round
  import nn_fixed_pkg::*;
#(
  parameter int IN_W  = 48,
  parameter int SHIFT = Q_FRAC_BITS
) (
  input  logic signed [IN_W-1:0] din,
  output logic [Q_W-1:0]         dout,
  output logic                   sat
);
  logic signed [IN_W-1:0] r;
  logic                   hi_ones;
  logic                   hi_zeros;

  assign r = din >>> SHIFT;

  // r fits in Q_W bits only if everything above the result sign bit matches it
  assign hi_ones  = &r[IN_W-1:Q_W-1];
  assign hi_zeros = ~|r[IN_W-1:Q_W-1];

  always_comb begin
    sat  = ~(hi_ones | hi_zeros);
    dout = r[Q_W-1:0];
    if (sat) dout = r[IN_W-1] ? SAT_MIN : SAT_MAX;
  end
endmodule

// File: rtl/neuron_mac.sv
// One-neuron multiply-accumulate feeding the sigmoid x1 input.
// Optional NEURON_MAC_OVF_EN adds a sticky saturation flag output (ovf).
module neuron_mac
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS  = 784,
  parameter int FRAC_BITS = Q_FRAC_BITS,
  parameter int ACC_W     = 48
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [Q_W-1:0] bias,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] in_data,
  input  logic [Q_W-1:0] in_weight,
  output logic           busy,
  output logic           out_valid,
`ifdef NEURON_MAC_OVF_EN
  output logic           ovf,
`endif
  output logic [Q_W-1:0] x1
);
  localparam int          P_W    = 2 * Q_W;
  localparam int          STAGES = 2;
  localparam logic [15:0] LAST   = 16'(N_INPUTS - 1);

  mac_state_e              state, nxt;
  logic [15:0]             count;
  logic [STAGES:1]         vld_pipe;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic [Q_W-1:0]          sat_dout;
  logic                    xfer, start_ok, load_x1;
`ifdef NEURON_MAC_OVF_EN
  logic                    sat_hit;
`else
  logic                    sat_unused;
`endif

  assign in_ready  = (state == ACCUM);
  assign xfer      = in_valid & in_ready;
  assign start_ok  = (state == IDLE) & start;
  assign busy      = (state == ACCUM) | (state == DRAIN);
  assign out_valid = (state == SCALE);
  assign load_x1   = (state == DRAIN) & (nxt == SCALE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ACCUM;
      ACCUM:   if (xfer && count == LAST) nxt = DRAIN;
      DRAIN:   if (vld_pipe == '0) nxt = SCALE;
      SCALE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // stage 1: product register; stage 2: accumulate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      vld_pipe <= '0;
      prod     <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
      if (xfer) begin
        prod  <= $signed(in_data) * $signed(in_weight);
        count <= count + 16'd1;
      end
      if (start_ok) begin
        // bias moved onto the Q10.24 product scale
        acc   <= {{(ACC_W-Q_W){bias[Q_W-1]}}, bias} << FRAC_BITS;
        count <= '0;
      end else if (vld_pipe[1]) begin
        acc <= acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
      end
    end
  end

  fixed_sat_round #(.IN_W(ACC_W), .SHIFT(FRAC_BITS)) u_sat (
    .din  (acc),
    .dout (sat_dout),
`ifdef NEURON_MAC_OVF_EN
    .sat  (sat_hit)
`else
    .sat  (sat_unused)
`endif
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       x1 <= '0;
    else if (load_x1) x1 <= sat_dout;
  end

`ifdef NEURON_MAC_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  ovf <= 1'b0;
    else if (start_ok)           ovf <= 1'b0;
    else if (load_x1 && sat_hit) ovf <= 1'b1;
  end
`endif
endmodule
